spi_master_fifo: RTL and testbench
==================================

# spi_master_fifo

Parametrised SPI master: the successor of the single-byte SPI register wrapper. It adds configurable word width, selectable CPOL/CPHA mode, multiple active-low chip selects, and TX/RX FIFOs with valid/ready handshakes, so the SoC bus side can queue display or sensor command streams without polling per byte. The block sits between the bus register file and the pads, in the same clock domain, masterClk.

## Interface
- DATA_W, 8, bits per SPI word
- FIFO_DEPTH, 4, entries in each of TX and RX FIFO; power of two, at least 2
- NUM_CS, 1, number of chip-select lines
- PRESC_W, 16, prescaler width
- masterClk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high; clock masterClk
- enable  in  1  engine may start new words while high
- cpol  in  1  SCK idle level
- cpha  in  1  0: sample on leading edge; 1: sample on trailing edge
- prescaler_reg  in  PRESC_W  SCK half-period = prescaler_reg+1 masterClk cycles
- tx_data  in  DATA_W  word to send, MSB first
- tx_dc  in  1  DC level for this word
- tx_cs  in  max(1,$clog2(NUM_CS))  chip-select index for this word
- tx_valid / tx_ready  in / out  1  TX push handshake
- rx_data  out  DATA_W  head of RX FIFO
- rx_valid / rx_ready  out / in  1  RX pop handshake
- ovf_clr  in  1  clears rx_overflow
- rx_overflow  out  1  sticky; a received word was dropped
- busy  out  1  engine not IDLE, or TX FIFO non-empty
- MOSI, SCK, DC  out  1  SPI pins
- CS  out  NUM_CS  active-low chip selects
- MISO  in  1  SPI data in

## Operation
- TX FIFO entry = {tx_cs, tx_dc, tx_data}. Push when tx_valid && tx_ready; tx_ready = !tx_full.
- RX FIFO: rx_valid = !rx_empty; rx_data is the head entry; pop when rx_valid && rx_ready.
- Push and pop in the same cycle are both legal at any fill level, including full (TX pop frees a slot only in the next cycle) and empty.
- Engine FSM: IDLE, SETUP, SHIFT, HOLD.
  - IDLE -> SETUP when enable && TX FIFO non-empty. On this edge: pop the entry, load the shift register, set DC, drive the selected CS low. cpol, cpha and prescaler_reg are latched only on the IDLE->SETUP edge.
  - SETUP: lasts 1 half-period. For cpha=0, MOSI = MSB during SETUP.
  - SHIFT: 2*DATA_W half-periods; SCK toggles at each half-period end.
    - cpha=0: sample MISO on odd (leading) edges, shift MOSI on even edges.
    - cpha=1: shift MOSI on leading edges (first leading edge presents the MSB), sample on trailing edges.
  - HOLD: 1 half-period with SCK at cpol. At the end, the received word is pushed to the RX FIFO. If the RX FIFO is full, the word is dropped and rx_overflow is set.
  - HOLD -> SETUP, keeping CS low (back-to-back), if enable && TX non-empty && next entry's cs equals the current one. A new entry is popped on this edge.
  - Otherwise HOLD -> IDLE with all CS high.
- enable deasserted mid-word: the current word completes; the engine then goes to IDLE.
- tx_cs >= NUM_CS: the word is shifted with no CS asserted; RX is still captured.
- rx_overflow: set has priority over ovf_clr in the same cycle.

## Timing
- Reset values: CS all 1, SCK 0, MOSI 0, DC 0, state IDLE, both FIFOs empty, tx_ready 1, rx_valid 0, rx_overflow 0, busy 0.
  - In IDLE after reset, SCK = latched cpol from the first cycle.
- Reset mid-transfer: immediate abort. FIFO contents are discarded and CS is released asynchronously.
- Push at edge N into an idle engine with an empty FIFO: busy=1 and the entry visible at N+1; CS low at N+2.
- Word time (CS low to CS high) = (2*DATA_W+2)*(prescaler_reg+1) cycles.
- RX word visible (rx_valid=1) 1 cycle after the HOLD end edge.
- Back-to-back same-cs words: CS stays low; no idle cycles between HOLD and SETUP.
- prescaler_reg=0: SCK = masterClk/2.

## Test plan
- Mode 0, prescaler 0, MISO looped to MOSI: push 0xA5 then 0x3C, both cs 0.
  - Expect 0xA5 then 0x3C on rx_data.
  - CS0 low continuously for 2*(18) = 36 cycles.
- Mode 3 (cpol=1, cpha=1), prescaler 3, MISO driven by a slave model returning 0x5A: push 0xFF.
  - SCK idles at 1; 8 rising edges, each 8 cycles apart.
  - rx_data = 0x5A.
- cs change: push (cs0, 0x11) then (cs1, 0x22) with NUM_CS=2.
  - CS0 rises before CS1 falls, with at least 1 IDLE cycle between.
  - DC follows tx_dc per word.
- Fill TX with FIFO_DEPTH+1 pushes while enable=0.
  - tx_ready=0 after 4 pushes.
  - Raise enable: all 4 words are sent in order.
- rx_ready=0, send 5 words.
  - The first 4 are held; the 5th is dropped and rx_overflow=1.
  - ovf_clr clears rx_overflow.
- Assert rst mid-SHIFT.
  - The same cycle: CS all high, SCK 0.
  - Afterwards: tx_ready=1, rx_valid=0.

Source files
------------

// File: rtl/spi_master_fifo.sv
// spi_master_fifo -- SPI master with TX/RX word FIFOs and valid/ready handshakes.
//
// Ports:
//   masterClk, rst         system clock; asynchronous active-high reset
//   enable                 engine may start new words while high
//   cpol, cpha             SPI mode (latched when a burst starts from IDLE)
//   prescaler_reg          SCK half-period = prescaler_reg+1 masterClk cycles
//   tx_data/tx_dc/tx_cs    TX word, its DC level and chip-select index
//   tx_valid/tx_ready      TX FIFO push handshake
//   rx_data                head of RX FIFO
//   rx_valid/rx_ready      RX FIFO pop handshake
//   ovf_clr, rx_overflow   sticky "received word dropped" flag and its clear
//   busy                   engine active or TX FIFO non-empty
//   MOSI, SCK, DC, CS      SPI pins (CS active low, one per slave)
//   MISO                   SPI data in

// Small show-ahead FIFO: o_head is the oldest entry whenever o_empty is low.
// Full/empty come from a registered count, so a pop frees a slot one cycle later.
module spi_master_fifo_q #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic         masterClk,
    input  logic         rst,
    input  logic         i_push,
    input  logic [W-1:0] i_data,
    input  logic         i_pop,
    output logic [W-1:0] o_head,
    output logic         o_full,
    output logic         o_empty
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_push;
    logic          w_pop;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_head  = r_mem[r_rd_ptr];

    // Storage carries no reset; only the pointers define what is valid.
    always_ff @(posedge masterClk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge masterClk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

module spi_master_fifo #(
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int NUM_CS     = 1,
    parameter int PRESC_W    = 16,
    localparam int CS_W      = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic               masterClk,
    input  logic               rst,
    input  logic               enable,
    input  logic               cpol,
    input  logic               cpha,
    input  logic [PRESC_W-1:0] prescaler_reg,
    input  logic [DATA_W-1:0]  tx_data,
    input  logic               tx_dc,
    input  logic [CS_W-1:0]    tx_cs,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic [DATA_W-1:0]  rx_data,
    output logic               rx_valid,
    input  logic               rx_ready,
    input  logic               ovf_clr,
    output logic               rx_overflow,
    output logic               busy,
    output logic               MOSI,
    output logic               SCK,
    output logic               DC,
    output logic [NUM_CS-1:0]  CS,
    input  logic               MISO
);
    localparam int TXW = CS_W + 1 + DATA_W;
    localparam int EW  = $clog2(2 * DATA_W);
    localparam logic [EW-1:0] EDGE_LAST = EW'(2 * DATA_W - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD} state_t;

    state_t              r_state;
    logic [PRESC_W-1:0]  r_div;
    logic [PRESC_W-1:0]  r_presc;
    logic                r_cpol;
    logic                r_cpha;
    logic [EW-1:0]       r_edge;
    logic [DATA_W-1:0]   r_tx_sr;
    logic [DATA_W-1:0]   r_rx_sr;
    logic [CS_W-1:0]     r_cur_cs;
    logic                r_sck;
    logic                r_mosi;
    logic                r_dc;
    logic [NUM_CS-1:0]   r_cs;
    logic                r_ovf;

    logic [TXW-1:0]      w_tx_head;
    logic                w_tx_full;
    logic                w_tx_empty;
    logic                w_rx_full;
    logic                w_rx_empty;
    logic [DATA_W-1:0]   w_head_data;
    logic                w_head_dc;
    logic [CS_W-1:0]     w_head_cs;
    logic [NUM_CS-1:0]   w_cs_dec;
    logic                w_tick;
    logic                w_start;
    logic                w_hold_end;
    logic                w_chain;
    logic                w_tx_pop;

    spi_master_fifo_q #(.W(TXW), .DEPTH(FIFO_DEPTH)) u_tx_q (
        .masterClk (masterClk),
        .rst       (rst),
        .i_push    (tx_valid && tx_ready),
        .i_data    ({tx_cs, tx_dc, tx_data}),
        .i_pop     (w_tx_pop),
        .o_head    (w_tx_head),
        .o_full    (w_tx_full),
        .o_empty   (w_tx_empty)
    );

    spi_master_fifo_q #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_rx_q (
        .masterClk (masterClk),
        .rst       (rst),
        .i_push    (w_hold_end),
        .i_data    (r_rx_sr),
        .i_pop     (rx_valid && rx_ready),
        .o_head    (rx_data),
        .o_full    (w_rx_full),
        .o_empty   (w_rx_empty)
    );

    assign w_head_data = w_tx_head[DATA_W-1:0];
    assign w_head_dc   = w_tx_head[DATA_W];
    assign w_head_cs   = w_tx_head[DATA_W+1 +: CS_W];

    // Active-low select pattern for the head entry; an out-of-range index
    // matches no line, so the word goes out with every CS high.
    for (genvar gi = 0; gi < NUM_CS; gi++) begin : g_cs_dec
        assign w_cs_dec[gi] = !(32'(w_head_cs) == gi);
    end

    assign w_tick     = (r_div == r_presc);
    assign w_start    = (r_state == ST_IDLE) && enable && !w_tx_empty;
    assign w_hold_end = (r_state == ST_HOLD) && w_tick;
    // Back-to-back only while the next word targets the same slave.
    assign w_chain    = w_hold_end && enable && !w_tx_empty && (w_head_cs == r_cur_cs);
    assign w_tx_pop   = w_start || w_chain;

    assign tx_ready    = !w_tx_full;
    assign rx_valid    = !w_rx_empty;
    assign rx_overflow = r_ovf;
    assign busy        = (r_state != ST_IDLE) || !w_tx_empty;
    assign MOSI        = r_mosi;
    assign SCK         = r_sck;
    assign DC          = r_dc;
    assign CS          = r_cs;

    always_ff @(posedge masterClk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_div    <= '0;
            r_presc  <= '0;
            r_cpol   <= 1'b0;
            r_cpha   <= 1'b0;
            r_edge   <= '0;
            r_tx_sr  <= '0;
            r_rx_sr  <= '0;
            r_cur_cs <= '0;
            r_sck    <= 1'b0;
            r_mosi   <= 1'b0;
            r_dc     <= 1'b0;
            r_cs     <= '1;
        end else begin
            // Half-period divider is parked at zero in IDLE so SETUP always
            // gets a full half-period.
            if (r_state == ST_IDLE || w_tick) r_div <= '0;
            else                              r_div <= r_div + 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (w_start) begin
                        r_state  <= ST_SETUP;
                        r_cpol   <= cpol;
                        r_cpha   <= cpha;
                        r_presc  <= prescaler_reg;
                        r_sck    <= cpol;
                        r_tx_sr  <= w_head_data;
                        r_dc     <= w_head_dc;
                        r_cur_cs <= w_head_cs;
                        r_cs     <= w_cs_dec;
                        if (!cpha) r_mosi <= w_head_data[DATA_W-1];
                    end
                end
                ST_SETUP: begin
                    if (w_tick) begin
                        r_state <= ST_SHIFT;
                        r_edge  <= '0;
                    end
                end
                ST_SHIFT: begin
                    if (w_tick) begin
                        r_sck <= ~r_sck;
                        // r_edge even = leading SCK edge, odd = trailing.
                        if (r_edge[0] == r_cpha) begin
                            r_rx_sr <= {r_rx_sr[DATA_W-2:0], MISO};
                        end else if (!r_cpha) begin
                            r_mosi  <= r_tx_sr[DATA_W-2];
                            r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
                        end else begin
                            r_mosi  <= r_tx_sr[DATA_W-1];
                            r_tx_sr <= {r_tx_sr[DATA_W-2:0], 1'b0};
                        end
                        if (r_edge == EDGE_LAST) r_state <= ST_HOLD;
                        else                     r_edge  <= r_edge + 1'b1;
                    end
                end
                ST_HOLD: begin
                    if (w_chain) begin
                        r_state <= ST_SETUP;
                        r_tx_sr <= w_head_data;
                        r_dc    <= w_head_dc;
                        if (!r_cpha) r_mosi <= w_head_data[DATA_W-1];
                    end else if (w_tick) begin
                        r_state <= ST_IDLE;
                        r_cs    <= '1;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Sticky drop flag; a new drop wins over a simultaneous clear.
    always_ff @(posedge masterClk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (w_hold_end && w_rx_full) begin
            r_ovf <= 1'b1;
        end else if (ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end
endmodule

// File: tb/tb_spi_master_fifo.sv
// tb_spi_master_fifo -- directed bench for spi_master_fifo (DATA_W=8,
// FIFO_DEPTH=4, NUM_CS=2). Received words are checked against a queue of
// expected values filled when the matching TX word is pushed.
module tb_spi_master_fifo;
    localparam int DATA_W     = 8;
    localparam int FIFO_DEPTH = 4;
    localparam int NUM_CS     = 2;
    localparam int PRESC_W    = 16;

    logic               masterClk = 1'b0;
    logic               rst = 1'b1;
    logic               enable = 1'b0;
    logic               cpol = 1'b0;
    logic               cpha = 1'b0;
    logic [PRESC_W-1:0] prescaler_reg = '0;
    logic [7:0]         tx_data = '0;
    logic               tx_dc = 1'b0;
    logic [0:0]         tx_cs = '0;
    logic               tx_valid = 1'b0;
    logic               tx_ready;
    logic [7:0]         rx_data;
    logic               rx_valid;
    logic               rx_ready = 1'b0;
    logic               ovf_clr = 1'b0;
    logic               rx_overflow;
    logic               busy;
    logic               MOSI;
    logic               SCK;
    logic               DC;
    logic [1:0]         CS;
    logic               MISO;

    logic               loop_en = 1'b1;
    logic               slave_miso = 1'b0;
    logic               mon_clr = 1'b0;
    assign MISO = loop_en ? MOSI : slave_miso;

    int total = 0;
    int bad = 0;
    logic [7:0] sb[$];

    spi_master_fifo #(
        .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH), .NUM_CS(NUM_CS), .PRESC_W(PRESC_W)
    ) dut (
        .masterClk(masterClk), .rst(rst), .enable(enable), .cpol(cpol), .cpha(cpha),
        .prescaler_reg(prescaler_reg), .tx_data(tx_data), .tx_dc(tx_dc), .tx_cs(tx_cs),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .ovf_clr(ovf_clr), .rx_overflow(rx_overflow), .busy(busy),
        .MOSI(MOSI), .SCK(SCK), .DC(DC), .CS(CS), .MISO(MISO)
    );

    always #5 masterClk = ~masterClk;

    int cyc = 0;
    always @(posedge masterClk) cyc <= cyc + 1;

    // Pin monitor and mode-3 slave (returns 0x5A on CS0), sampled mid-cycle.
    logic       prev_sck = 1'b0;
    logic [1:0] prev_cs = 2'b11;
    logic [7:0] slave_sr = 8'h5A;
    int cs0_len = 0, cs0_last = 0, cs0_runs = 0, cs0_rise_cyc = 0, cs1_fall_cyc = 0;
    int rise_cnt = 0, last_rise = 0, gap_min = 0, gap_max = 0;
    logic dc_cs0 = 1'b0, dc_cs1 = 1'b0, both_low = 1'b0;

    always @(negedge masterClk) begin
        if (mon_clr) begin
            cs0_last = 0; cs0_runs = 0; cs0_rise_cyc = 0; cs1_fall_cyc = 0;
            rise_cnt = 0; last_rise = 0; gap_min = 1000000; gap_max = 0;
            dc_cs0 = 1'b0; dc_cs1 = 1'b0; both_low = 1'b0;
        end else begin
            if (!CS[0] && !prev_cs[0] && SCK && !prev_sck) begin
                if (rise_cnt > 0) begin
                    if (cyc - last_rise < gap_min) gap_min = cyc - last_rise;
                    if (cyc - last_rise > gap_max) gap_max = cyc - last_rise;
                end
                rise_cnt = rise_cnt + 1;
                last_rise = cyc;
            end
            if (!CS[0] && prev_cs[0]) cs0_len = 1;
            else if (!CS[0]) cs0_len = cs0_len + 1;
            if (CS[0] && !prev_cs[0]) begin
                cs0_runs = cs0_runs + 1;
                cs0_last = cs0_len;
                cs0_rise_cyc = cyc;
            end
            if (!CS[1] && prev_cs[1]) cs1_fall_cyc = cyc;
            if (CS == 2'b00) both_low = 1'b1;
            if (!CS[0]) dc_cs0 = DC;
            if (!CS[1]) dc_cs1 = DC;
        end
        if (!CS[0] && prev_cs[0]) begin
            slave_sr = 8'h5A;
        end else if (!CS[0] && !SCK && prev_sck) begin
            slave_miso = slave_sr[7];
            slave_sr = {slave_sr[6:0], 1'b0};
        end
        prev_sck = SCK;
        prev_cs = CS;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge masterClk);
    endtask

    task automatic clr_mon();
        mon_clr = 1'b1;
        tick(2);
        mon_clr = 1'b0;
    endtask

    // Called at a negedge; drives one cycle of tx_valid.
    task automatic push(input logic [7:0] d, input logic dc, input logic cs, output logic acc);
        tx_data = d; tx_dc = dc; tx_cs = cs; tx_valid = 1'b1;
        acc = tx_ready;
        @(negedge masterClk);
        tx_valid = 1'b0;
        $display("push data=%02h dc=%0d cs=%0d accepted=%0d", d, dc, cs, acc);
    endtask

    task automatic push_wait(input logic [7:0] d, input logic dc, input logic cs);
        int n = 0;
        logic acc;
        while (!tx_ready && n < 200) begin
            @(negedge masterClk);
            n++;
        end
        check("push_wait_timeout", 32'(n < 200), 32'd1);
        push(d, dc, cs, acc);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 3000) begin
            @(negedge masterClk);
            n++;
        end
        check({tag, "_idle_timeout"}, 32'(busy), 32'd0);
        tick(2);
    endtask

    task automatic pop_rx(input string tag);
        int n = 0;
        logic [7:0] exp;
        while (!rx_valid && n < 3000) begin
            @(negedge masterClk);
            n++;
        end
        check({tag, "_rx_valid"}, 32'(rx_valid), 32'd1);
        if (rx_valid) begin
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                check(tag, 32'(rx_data), 32'(exp));
            end else begin
                check({tag, "_unexpected"}, 32'(rx_data), 32'hFFFF_FFFF);
            end
            $display("pop rx_data=%02h", rx_data);
            rx_ready = 1'b1;
            @(negedge masterClk);
            rx_ready = 1'b0;
        end
    endtask

    initial begin
        logic acc;
        int n_acc;
        int n;

        // Reset state
        tick(3);
        check("rst_cs", 32'(CS), 32'h3);
        check("rst_sck", 32'(SCK), 32'd0);
        check("rst_mosi", 32'(MOSI), 32'd0);
        check("rst_dc", 32'(DC), 32'd0);
        check("rst_tx_ready", 32'(tx_ready), 32'd1);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_ovf", 32'(rx_overflow), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick(1);
        clr_mon();

        // Mode 0, prescaler 0, loopback: two back-to-back words on cs0
        enable = 1'b1; cpol = 1'b0; cpha = 1'b0; prescaler_reg = 16'd0; loop_en = 1'b1;
        push(8'hA5, 1'b0, 1'b0, acc); sb.push_back(8'hA5);
        check("t1_busy_after_push", 32'(busy), 32'd1);
        check("t1_cs_before_start", 32'(CS), 32'h3);
        push(8'h3C, 1'b1, 1'b0, acc); sb.push_back(8'h3C);
        check("t1_cs0_low", 32'(CS), 32'h2);
        wait_idle("t1");
        check("t1_cs0_len", 32'(cs0_last), 32'd36);
        check("t1_cs0_runs", 32'(cs0_runs), 32'd1);
        pop_rx("t1_rx0");
        pop_rx("t1_rx1");

        // Mode 3, prescaler 3, slave returns 0x5A
        clr_mon();
        loop_en = 1'b0; cpol = 1'b1; cpha = 1'b1; prescaler_reg = 16'd3;
        push(8'hFF, 1'b0, 1'b0, acc); sb.push_back(8'h5A);
        wait_idle("t2");
        check("t2_rises", 32'(rise_cnt), 32'd8);
        check("t2_gap_min", 32'(gap_min), 32'd8);
        check("t2_gap_max", 32'(gap_max), 32'd8);
        check("t2_cs0_len", 32'(cs0_last), 32'd72);
        check("t2_sck_idle", 32'(SCK), 32'd1);
        pop_rx("t2_rx");

        // Chip-select change between words
        clr_mon();
        loop_en = 1'b1; cpol = 1'b0; cpha = 1'b0; prescaler_reg = 16'd0;
        push(8'h11, 1'b1, 1'b0, acc); sb.push_back(8'h11);
        push(8'h22, 1'b0, 1'b1, acc); sb.push_back(8'h22);
        wait_idle("t3");
        check("t3_no_overlap", 32'(both_low), 32'd0);
        check("t3_cs0_runs", 32'(cs0_runs), 32'd1);
        check("t3_gap_ge1", 32'(cs1_fall_cyc - cs0_rise_cyc >= 1), 32'd1);
        check("t3_dc_cs0", 32'(dc_cs0), 32'd1);
        check("t3_dc_cs1", 32'(dc_cs1), 32'd0);
        pop_rx("t3_rx0");
        pop_rx("t3_rx1");

        // Fill TX while disabled
        enable = 1'b0;
        n_acc = 0;
        for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
            push(8'(8'h81 + i), 1'b0, 1'b0, acc);
            if (acc) begin
                n_acc++;
                sb.push_back(8'(8'h81 + i));
            end
        end
        check("t4_accepted", 32'(n_acc), 32'd4);
        check("t4_tx_ready_full", 32'(tx_ready), 32'd0);
        check("t4_busy_disabled", 32'(busy), 32'd1);
        check("t4_cs_disabled", 32'(CS), 32'h3);
        enable = 1'b1;
        wait_idle("t4");
        check("t4_no_ovf", 32'(rx_overflow), 32'd0);
        for (int i = 0; i < 4; i++) pop_rx("t4_rx");

        // RX overflow
        for (int i = 0; i < 5; i++) begin
            push_wait(8'(8'h01 + i), 1'b0, 1'b0);
            if (i < 4) sb.push_back(8'(8'h01 + i));
        end
        wait_idle("t5");
        check("t5_ovf_set", 32'(rx_overflow), 32'd1);
        for (int i = 0; i < 4; i++) pop_rx("t5_rx");
        check("t5_rx_empty", 32'(rx_valid), 32'd0);
        check("t5_ovf_sticky", 32'(rx_overflow), 32'd1);
        ovf_clr = 1'b1;
        tick(1);
        ovf_clr = 1'b0;
        check("t5_ovf_clr", 32'(rx_overflow), 32'd0);

        // Reset mid-SHIFT
        push(8'h77, 1'b0, 1'b0, acc); sb.push_back(8'h77);
        wait_idle("t6_pre");
        check("t6_rx_held", 32'(rx_valid), 32'd1);
        cpol = 1'b1; cpha = 1'b1; prescaler_reg = 16'd3;
        push(8'h99, 1'b0, 1'b0, acc);
        push(8'h66, 1'b0, 1'b0, acc);
        n = 0;
        while (CS[0] && n < 100) begin
            @(negedge masterClk);
            n++;
        end
        tick(10);
        check("t6_cs_low_before_rst", 32'(CS), 32'h2);
        #2 rst = 1'b1;
        #1;
        check("t6_rst_cs", 32'(CS), 32'h3);
        check("t6_rst_sck", 32'(SCK), 32'd0);
        tick(2);
        check("t6_tx_ready", 32'(tx_ready), 32'd1);
        check("t6_rx_valid", 32'(rx_valid), 32'd0);
        check("t6_busy", 32'(busy), 32'd0);
        sb.delete();
        rst = 1'b0;
        tick(3);
        check("t6_after_cs", 32'(CS), 32'h3);
        check("t6_after_busy", 32'(busy), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
